// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: request/response ports of both requesters plus the shared memory port.
interface memory_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  req0_valid, req0_write, req0_ready;
   logic [ADDR_WIDTH-1:0] req0_address;
   logic [DATA_WIDTH-1:0] req0_data;
   logic                  req1_valid, req1_write, req1_ready;
   logic [ADDR_WIDTH-1:0] req1_address;
   logic [DATA_WIDTH-1:0] req1_data;
   logic                  resp0_valid, resp0_ready;
   logic [DATA_WIDTH-1:0] resp0_data;
   logic                  resp1_valid, resp1_ready;
   logic [DATA_WIDTH-1:0] resp1_data;
   logic [ADDR_WIDTH-1:0] mem_read_address, mem_write_address;
   logic [DATA_WIDTH-1:0] mem_write_data, mem_read_data;
   logic                  mem_write_enable;
   modport slave (
      input  req0_valid, req0_write, req0_address, req0_data,
      input  req1_valid, req1_write, req1_address, req1_data,
      output req0_ready, req1_ready,
      output resp0_valid, resp0_data, resp1_valid, resp1_data,
      input  resp0_ready, resp1_ready,
      output mem_read_address, mem_write_address, mem_write_data, mem_write_enable,
      input  mem_read_data
   );
   modport master (
      output req0_valid, req0_write, req0_address, req0_data,
      output req1_valid, req1_write, req1_address, req1_data,
      input  req0_ready, req1_ready,
      input  resp0_valid, resp0_data, resp1_valid, resp1_data,
      output resp0_ready, resp1_ready,
      input  mem_read_address, mem_write_address, mem_write_data, mem_write_enable,
      output mem_read_data
   );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: grants one of two requesters per cycle to a shared memory and holds read responses.
// Round-robin by default; define MEMORY_ARBITER_FIXED_PRIORITY_EN to make requester 0 always win.
module memory_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input logic             clock,
   input logic             reset,
   memory_arbiter_if.slave bus
);
   logic [1:0]            valid, write, rready, elig, grant, rd_hs, rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q [2];
   logic [DATA_WIDTH-1:0] rdata_d [2];
   logic [ADDR_WIDTH-1:0] addr;
   assign valid  = {bus.req1_valid, bus.req0_valid};
   assign write  = {bus.req1_write, bus.req0_write};
   assign rready = {bus.resp1_ready, bus.resp0_ready};
   // a read may only proceed when its response slot is empty or draining this edge
   assign elig   = valid & (write | ~rvalid_q | rready);
`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
   assign grant = {elig[1] & ~elig[0], elig[0]} & {2{reset}};
`else
   logic last_q, last_d;
   assign grant  = {elig[1] & (~elig[0] | ~last_q), elig[0] & (~elig[1] | last_q)} & {2{reset}};
   assign last_d = |grant ? grant[1] : last_q;
   always_ff @(posedge clock or negedge reset)
      if (!reset) last_q <= 1'b1;
      else last_q <= last_d;
`endif
   assign rd_hs                 = grant & ~write;
   assign addr                  = grant[1] ? bus.req1_address : bus.req0_address;
   assign bus.mem_read_address  = addr;
   assign bus.mem_write_address = addr;
   assign bus.mem_write_data    = grant[1] ? bus.req1_data : bus.req0_data;
   assign bus.mem_write_enable  = |(grant & write);
   assign bus.req0_ready        = grant[0];
   assign bus.req1_ready        = grant[1];
   assign bus.resp0_valid       = rvalid_q[0];
   assign bus.resp1_valid       = rvalid_q[1];
   assign bus.resp0_data        = rdata_q[0];
   assign bus.resp1_data        = rdata_q[1];
   always_comb begin
      rvalid_d = rd_hs | (rvalid_q & ~rready);
      for (int i = 0; i < 2; i++) rdata_d[i] = rd_hs[i] ? bus.mem_read_data : rdata_q[i];
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         rvalid_q <= '0;
         rdata_q  <= '{default: '0};
      end else begin
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
endmodule
